// File: rtl/lda_cmd_sched_pkg.sv
// Shared definitions for the line-draw command scheduler: register map, FSM encoding, command record.
// No logic; latency and backpressure are properties of the modules that import this package.
package lda_cmd_sched_pkg;

    localparam logic [2:0] ADDR_X0     = 3'd0;
    localparam logic [2:0] ADDR_X1     = 3'd1;
    localparam logic [2:0] ADDR_Y0     = 3'd2;
    localparam logic [2:0] ADDR_Y1     = 3'd3;
    localparam logic [2:0] ADDR_COLOUR = 3'd4;
    localparam logic [2:0] ADDR_COMMIT = 3'd5;
    localparam logic [2:0] ADDR_CLR    = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;
    localparam int CMD_W = 2 * X_W + 2 * Y_W + COL_W;

    localparam int CMD_COL_LSB = 0;
    localparam int CMD_Y1_LSB  = CMD_COL_LSB + COL_W;
    localparam int CMD_Y0_LSB  = CMD_Y1_LSB + Y_W;
    localparam int CMD_X1_LSB  = CMD_Y0_LSB + Y_W;
    localparam int CMD_X0_LSB  = CMD_X1_LSB + X_W;

    // Field order matches the CMD_*_LSB offsets above (x0 in the MSBs).
    typedef struct packed {
        logic [X_W-1:0]   x0;
        logic [X_W-1:0]   x1;
        logic [Y_W-1:0]   y0;
        logic [Y_W-1:0]   y1;
        logic [COL_W-1:0] colour;
    } cmd_t;

    // Status flags sit directly above the CW-bit count field.
    localparam int STS_FULL_OFS  = 0;
    localparam int STS_EMPTY_OFS = 1;
    localparam int STS_BUSY_OFS  = 2;
    localparam int STS_OVF_OFS   = 3;

endpackage

// File: rtl/lda_cmd_fifo.sv
// Command FIFO, DEPTH entries of DW bits, synchronous push/pop with head always visible on dout.
// Latency: a push is visible on dout one edge later. Backpressure: a push when full without a pop is dropped and flagged.
module lda_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3,
    parameter int DW    = 37
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          push_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot in the same cycle, so full+push+pop is accepted.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lda_cmd_sched.sv
// Line-draw command scheduler: bus-written staging, COMMIT queues a command, FSM issues one command at a time.
// Latency: COMMIT at edge N on an idle block gives lda_go between edges N+2 and N+3.
// Backpressure: engine paced by lda_done; commits beyond FIFO capacity are dropped and set sticky overflow.
module lda_cmd_sched
    import lda_cmd_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        wr_en,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rd_data,
    input  logic        lda_done,
    output logic        lda_go,
    output logic [8:0]  lda_x0,
    output logic [8:0]  lda_x1,
    output logic [7:0]  lda_y0,
    output logic [7:0]  lda_y1,
    output logic [2:0]  lda_colour,
    output logic        busy,
    output logic        cmd_done
);

    cmd_t             stage;
    cmd_t             cmd_q;
    state_t           state_q;
    state_t           state_d;
    logic             overflow;
    logic             cmd_done_q;
    logic             commit;
    logic             clr;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[15:9];

    assign commit = wr_en && (addr == ADDR_COMMIT);
    assign clr    = wr_en && (addr == ADDR_CLR);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stage <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_X0:     stage.x0     <= wdata[8:0];
                ADDR_X1:     stage.x1     <= wdata[8:0];
                ADDR_Y0:     stage.y0     <= wdata[7:0];
                ADDR_Y1:     stage.y1     <= wdata[7:0];
                ADDR_COLOUR: stage.colour <= wdata[2:0];
                default:     stage        <= stage;
            endcase
        end
    end

    lda_cmd_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .DW    (CMD_W)
    ) u_fifo (
        .clock     (clock),
        .resetN    (resetN),
        .push      (commit),
        .pop       (fifo_pop),
        .din       (stage),
        .dout      (fifo_dout),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (fifo_drop)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        lda_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                state_d  = ST_START;
            end
            ST_START: begin
                lda_go  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lda_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine-facing fields only move on the LOAD edge so they stay stable through START and WAIT.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cmd_q      <= '0;
            cmd_done_q <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                cmd_q <= cmd_t'(fifo_dout);
            end
            cmd_done_q <= (state_q == ST_WAIT) && lda_done;
        end
    end

    assign lda_x0     = cmd_q.x0;
    assign lda_x1     = cmd_q.x1;
    assign lda_y0     = cmd_q.y0;
    assign lda_y1     = cmd_q.y1;
    assign lda_colour = cmd_q.colour;
    assign cmd_done   = cmd_done_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        rd_data = '0;
        if (addr == ADDR_STATUS) begin
            rd_data[CW-1:0]             = fifo_count;
            rd_data[CW + STS_FULL_OFS]  = fifo_full;
            rd_data[CW + STS_EMPTY_OFS] = fifo_empty;
            rd_data[CW + STS_BUSY_OFS]  = busy;
            rd_data[CW + STS_OVF_OFS]   = overflow;
        end
    end

endmodule

// File: tb/tb_lda_cmd_sched.sv
// Directed bench for lda_cmd_sched: stimulus queues expected commands, a negedge monitor checks every go pulse.
module tb_lda_cmd_sched;

    logic        clock = 1'b0;
    logic        resetN;
    logic        wr_en;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd_data;
    logic        lda_done;
    logic        lda_go;
    logic [8:0]  lda_x0, lda_x1;
    logic [7:0]  lda_y0, lda_y1;
    logic [2:0]  lda_colour;
    logic        busy;
    logic        cmd_done;

    int errors = 0;
    int checks = 0;
    int go_cnt = 0;
    int done_cnt = 0;
    int base_go, base_done;
    logic prev_go = 1'b0;
    logic prev_done = 1'b0;
    logic [36:0] exp_q [$];
    logic [8:0] m_x0, m_x1;
    logic [7:0] m_y0, m_y1;
    logic [2:0] m_col;

    lda_cmd_sched #(.DEPTH(4), .CW(3)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rd_data    (rd_data),
        .lda_done   (lda_done),
        .lda_go     (lda_go),
        .lda_x0     (lda_x0),
        .lda_x1     (lda_x1),
        .lda_y0     (lda_y0),
        .lda_y1     (lda_y1),
        .lda_colour (lda_colour),
        .busy       (busy),
        .cmd_done   (cmd_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every go pulse must be one cycle wide and carry the oldest outstanding command.
    always @(negedge clock) begin
        if (!resetN) begin
            prev_go   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (lda_go) begin
                go_cnt++;
                check("go_one_cycle", 64'(prev_go), 64'(0));
                check("go_has_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    check("go_cmd", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}), 64'(exp_q.pop_front()));
                end
            end
            if (cmd_done) begin
                done_cnt++;
                check("cmd_done_one_cycle", 64'(prev_done), 64'(0));
            end
            prev_go   = lda_go;
            prev_done = cmd_done;
        end
    end

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        case (a)
            3'd0: m_x0  = d[8:0];
            3'd1: m_x1  = d[8:0];
            3'd2: m_y0  = d[7:0];
            3'd3: m_y1  = d[7:0];
            3'd4: m_col = d[2:0];
            default: ;
        endcase
        @(negedge clock);
        wr_en = 1'b0;
        addr  = 3'd7;
        wdata = 16'h0;
    endtask

    task automatic do_commit(input bit accept);
        if (accept) exp_q.push_back({m_x0, m_x1, m_y0, m_y1, m_col});
        do_write(3'd5, 16'h0);
    endtask

    // Status layout for CW=3: count[2:0], full[3], empty[4], busy[5], overflow[6].
    task automatic chk_sts(input string nm, input int cnt, input bit fl, input bit em, input bit bz, input bit ov);
        logic [15:0] e;
        e = 16'(cnt) | (16'(fl) << 3) | (16'(em) << 4) | (16'(bz) << 5) | (16'(ov) << 6);
        addr = 3'd7;
        #1;
        check(nm, 64'(rd_data), 64'(e));
    endtask

    task automatic wait_go(input string nm);
        int n = 0;
        while (!lda_go && n < 20) begin
            @(negedge clock);
            n++;
        end
        check(nm, 64'(lda_go), 64'(1));
    endtask

    task automatic release_one(input bit expect_next);
        lda_done = 1'b1;
        @(negedge clock);
        lda_done = 1'b0;
        if (expect_next) begin
            wait_go("next_go_timeout");
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; wr_en = 1'b0; addr = 3'd7; wdata = 16'h0; lda_done = 1'b0;
        m_x0 = '0; m_x1 = '0; m_y0 = '0; m_y1 = '0; m_col = '0;
        #2;
        check("rst_go", 64'(lda_go), 64'(0));
        check("rst_outs", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cmd_done", 64'(cmd_done), 64'(0));
        chk_sts("rst_status", 0, 0, 1, 0, 0);
        addr = 3'd0;
        #1;
        check("rd_data_non_status", 64'(rd_data), 64'(0));
        addr = 3'd7;
        @(negedge clock); @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        // Single line with exact go timing.
        do_write(3'd0, 16'd10); do_write(3'd1, 16'd200); do_write(3'd2, 16'd5);
        do_write(3'd3, 16'd100); do_write(3'd4, 16'd3);
        do_commit(1);
        check("t1_go_n0", 64'(lda_go), 64'(0));
        @(negedge clock);
        check("t1_go_n1", 64'(lda_go), 64'(0));
        @(negedge clock);
        check("t1_go_n2", 64'(lda_go), 64'(1));
        check("t1_outs", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}),
              64'({9'd10, 9'd200, 8'd5, 8'd100, 3'd3}));
        @(negedge clock);
        check("t1_go_n3", 64'(lda_go), 64'(0));
        repeat (20) @(negedge clock);
        chk_sts("t1_wait_status", 0, 0, 1, 1, 0);
        #1 base_done = done_cnt;
        lda_done = 1'b1;
        @(negedge clock);
        lda_done = 1'b0;
        check("t1_cmd_done", 64'(cmd_done), 64'(1));
        check("t1_busy_fall", 64'(busy), 64'(0));
        @(negedge clock);
        check("t1_cmd_done_low", 64'(cmd_done), 64'(0));
        chk_sts("t1_idle_status", 0, 0, 1, 0, 0);
        #1 check("t1_done_count", 64'(done_cnt - base_done), 64'(1));

        // Queue fill: first command leaves via LOAD, four fill the FIFO, sixth is dropped.
        base_go = go_cnt; base_done = done_cnt;
        for (int i = 0; i < 6; i++) begin
            do_write(3'd0, 16'(20 + i));
            do_commit(i < 5);
        end
        chk_sts("fill_status", 4, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) release_one(i < 4);
        repeat (4) @(negedge clock);
        #1;
        check("fill_go_count", 64'(go_cnt - base_go), 64'(5));
        check("fill_done_count", 64'(done_cnt - base_done), 64'(5));
        check("fill_queue_drained", 64'(exp_q.size()), 64'(0));
        chk_sts("fill_drained_status", 0, 0, 1, 0, 1);
        do_write(3'd6, 16'h0);
        chk_sts("clr_overflow", 0, 0, 1, 0, 0);

        // Full FIFO, COMMIT on the LOAD edge: push and pop together.
        do_write(3'd0, 16'h1AA);
        for (int i = 0; i < 5; i++) do_commit(1);
        chk_sts("full_before_load", 4, 1, 0, 1, 0);
        lda_done = 1'b1;
        @(negedge clock);
        lda_done = 1'b0;
        @(negedge clock);
        do_commit(1);
        chk_sts("pushpop_status", 4, 1, 0, 1, 0);
        check("pushpop_go", 64'(lda_go), 64'(1));
        @(negedge clock);
        release_one(1);
        release_one(1);
        chk_sts("two_queued", 2, 0, 0, 1, 0);

        // Staging writes during WAIT must not disturb the engine-facing fields.
        do_write(3'd0, 16'h055); do_write(3'd1, 16'h0AA); do_write(3'd2, 16'h11);
        do_write(3'd3, 16'h22); do_write(3'd4, 16'h5);
        check("stable_outs", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}),
              64'({9'h1AA, 9'd200, 8'd5, 8'd100, 3'd3}));

        // Asynchronous reset in WAIT with two commands queued.
        resetN = 1'b0;
        #1;
        check("midrst_go", 64'(lda_go), 64'(0));
        check("midrst_outs", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        chk_sts("midrst_status", 0, 0, 1, 0, 0);
        exp_q.delete();
        m_x0 = '0; m_x1 = '0; m_y0 = '0; m_y1 = '0; m_col = '0;
        @(negedge clock);
        resetN = 1'b1;
        #1 base_go = go_cnt;
        repeat (10) @(negedge clock);
        #1;
        check("postrst_no_go", 64'(go_cnt - base_go), 64'(0));
        check("postrst_busy", 64'(busy), 64'(0));

        // lda_done ignored in IDLE; held high into WAIT completes on the first WAIT edge.
        base_done = done_cnt; base_go = go_cnt;
        lda_done = 1'b1;
        repeat (3) @(negedge clock);
        #1 check("done_idle_ignored", 64'(done_cnt - base_done), 64'(0));
        do_commit(1);
        @(negedge clock);
        @(negedge clock);
        check("early_done_go", 64'(lda_go), 64'(1));
        check("reset_cleared_staging", 64'({lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}), 64'(0));
        @(negedge clock);
        check("early_done_go_low", 64'(lda_go), 64'(0));
        check("early_done_not_yet", 64'(cmd_done), 64'(0));
        @(negedge clock);
        check("early_done_pulse", 64'(cmd_done), 64'(1));
        lda_done = 1'b0;
        @(negedge clock);
        check("early_done_pulse_low", 64'(cmd_done), 64'(0));
        check("early_done_idle", 64'(busy), 64'(0));
        #1 check("early_done_go_count", 64'(go_cnt - base_go), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
